// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS lane decoder: control tokens, token-to-control
// mapping and the alignment state machine encoding.
package tmds_pkg;

    localparam logic [9:0] TokenC00 = 10'b1101010100;
    localparam logic [9:0] TokenC01 = 10'b0010101011;
    localparam logic [9:0] TokenC10 = 10'b0101010100;
    localparam logic [9:0] TokenC11 = 10'b1010101011;

    typedef enum logic {
        SEARCH,
        LOCKED
    } tmdsState_e;

    function automatic logic isControlToken(input logic [9:0] sym);
        return (sym == TokenC00) || (sym == TokenC01) ||
               (sym == TokenC10) || (sym == TokenC11);
    endfunction

    function automatic logic [1:0] tokenToC(input logic [9:0] sym);
        logic [1:0] c;
        c = 2'b00;
        case (sym)
            TokenC01: c = 2'b01;
            TokenC10: c = 2'b10;
            TokenC11: c = 2'b11;
            default:  c = 2'b00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Registered TMDS symbol decode: recognises control tokens and undoes the
// transition-minimising XOR/XNOR coding of data symbols.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic [9:0] sym_i,
    input  logic       enable_i,
    output logic [7:0] data_o,
    output logic [1:0] c_o,
    output logic       de_o
);

    logic [7:0] data_q, data_d;
    logic [1:0] c_q, c_d;
    logic       de_q, de_d;
    logic [7:0] symData;
    logic [7:0] decoded;

    // Decode one symbol; control bits stick across data periods, and data is
    // only released while the lane is aligned.
    always_comb begin
        symData    = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
        decoded    = '0;
        decoded[0] = symData[0];
        for (int i = 1; i < 8; i++) begin
            decoded[i] = sym_i[8] ? (symData[i] ^ symData[i-1])
                                  : ~(symData[i] ^ symData[i-1]);
        end
        c_d    = c_q;
        de_d   = 1'b0;
        data_d = '0;
        if (isControlToken(sym_i)) begin
            c_d = tokenToC(sym_i);
        end else if (enable_i) begin
            de_d   = 1'b1;
            data_d = decoded;
        end
    end

    // Output register for the decoded symbol.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            c_q    <= '0;
            de_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            c_q    <= c_d;
            de_q   <= de_d;
        end
    end

    assign data_o = data_q;
    assign c_o    = c_q;
    assign de_o   = de_q;

endmodule

// File: rtl/tmds_decoder.sv
// One-lane TMDS receiver: slices 10-bit symbols out of the unaligned
// deserializer stream, hunts for the symbol boundary using control tokens and
// hands aligned symbols to the registered decode stage.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int C_lock_count   = 8,
    parameter int C_search_dwell = 4096,
    parameter int C_timeout      = 65536
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic [9:0] in_word,
    output logic [7:0] out_data,
    output logic [1:0] out_c,
    output logic       out_de,
    output logic       out_locked,
    output logic [3:0] out_offset
);

    // The run counter must be able to hold the lock threshold itself.
    localparam int RunW     = $clog2(C_lock_count + 1);
    localparam int DwellW   = $clog2(C_search_dwell);
    localparam int TimeoutW = $clog2(C_timeout);

    localparam logic [RunW-1:0]     RunLock     = RunW'(C_lock_count);
    localparam logic [DwellW-1:0]   DwellLast   = DwellW'(C_search_dwell - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(C_timeout - 1);

    logic [9:0]          prev_q, sym_q, symPrev_q, slice_d;
    logic [18:0]         window;
    logic [3:0]          offset_q, offset_d, offsetNext;
    tmdsState_e          state_q, state_d;
    logic [RunW-1:0]     run_q, run_d, runNext;
    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic [TimeoutW-1:0] timeout_q, timeout_d;
    logic                skip_q, skip_d;
    logic                symIsToken;
    logic                lockNext;

    assign offsetNext = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    assign symIsToken = isControlToken(sym_q);

    // Pick the 10-bit slice at the current bit offset out of the two most
    // recent words; the top window bit is never needed for offsets 0..9.
    always_comb begin
        window  = {in_word[8:0], prev_q};
        slice_d = window[9:0];
        case (offset_q)
            4'd1:    slice_d = window[10:1];
            4'd2:    slice_d = window[11:2];
            4'd3:    slice_d = window[12:3];
            4'd4:    slice_d = window[13:4];
            4'd5:    slice_d = window[14:5];
            4'd6:    slice_d = window[15:6];
            4'd7:    slice_d = window[16:7];
            4'd8:    slice_d = window[17:8];
            4'd9:    slice_d = window[18:9];
            default: slice_d = window[9:0];
        endcase
    end

    // Word history and sliced-symbol pipeline.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            sym_q     <= '0;
            symPrev_q <= '0;
        end else begin
            prev_q    <= in_word;
            sym_q     <= slice_d;
            symPrev_q <= sym_q;
        end
    end

    // Alignment FSM: count repeated tokens to lock, step the offset when the
    // dwell expires, and drop lock when tokens stop arriving.
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        run_d     = run_q;
        dwell_d   = dwell_q;
        timeout_d = timeout_q;
        skip_d    = 1'b0;
        runNext   = '0;
        case (state_q)
            SEARCH: begin
                if (skip_q) begin
                    runNext = '0;
                end else if (symIsToken && (sym_q == symPrev_q)) begin
                    runNext = (run_q == RunLock) ? run_q : run_q + 1'b1;
                end else if (symIsToken) begin
                    runNext = RunW'(1);
                end
                run_d   = runNext;
                dwell_d = (dwell_q == DwellLast) ? dwell_q : dwell_q + 1'b1;
                if (runNext >= RunLock) begin
                    state_d   = LOCKED;
                    run_d     = '0;
                    dwell_d   = '0;
                    timeout_d = '0;
                end else if (dwell_q == DwellLast) begin
                    offset_d = offsetNext;
                    run_d    = '0;
                    dwell_d  = '0;
                    skip_d   = 1'b1;
                end
            end
            LOCKED: begin
                if (symIsToken) begin
                    timeout_d = '0;
                end else if (timeout_q == TimeoutLast) begin
                    state_d   = SEARCH;
                    offset_d  = offsetNext;
                    timeout_d = '0;
                    run_d     = '0;
                    dwell_d   = '0;
                    skip_d    = 1'b1;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Alignment state and counters.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            offset_q  <= '0;
            run_q     <= '0;
            dwell_q   <= '0;
            timeout_q <= '0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            run_q     <= run_d;
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
            skip_q    <= skip_d;
        end
    end

    // Gate decode with the upcoming lock state so out_de and out_locked
    // always change together.
    assign lockNext   = (state_d == LOCKED);
    assign out_locked = (state_q == LOCKED);
    assign out_offset = offset_q;

    tmds_symbol_decode uDecode (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .sym_i     (sym_q),
        .enable_i  (lockNext),
        .data_o    (out_data),
        .c_o       (out_c),
        .de_o      (out_de)
    );

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: drives rotated TMDS symbol streams and compares every
// output each cycle against a behavioural lane model, plus directed checks.
module tb_tmds_decoder;

    localparam int LockCount = 8;
    localparam int Dwell     = 16;
    localparam int Timeout   = 64;

    localparam logic [9:0] TokC00 = 10'b1101010100;
    localparam logic [9:0] TokC01 = 10'b0010101011;
    localparam logic [9:0] TokC10 = 10'b0101010100;
    localparam logic [9:0] TokC11 = 10'b1010101011;

    logic       clk_pixel;
    logic       rst_n;
    logic [9:0] in_word;
    logic [7:0] out_data;
    logic [1:0] out_c;
    logic       out_de;
    logic       out_locked;
    logic [3:0] out_offset;

    int checkCount = 0;
    int passCount  = 0;

    int         rot = 0;
    logic [9:0] lastSym = '0;

    // Reference model state
    logic [9:0] mPrev, mSym, mSymPrev;
    int         mOffset, mRun, mDwell, mTimeout;
    bit         mLocked, mSkip, mDe;
    logic [7:0] mData;
    logic [1:0] mC;

    tmds_decoder #(
        .C_lock_count   (LockCount),
        .C_search_dwell (Dwell),
        .C_timeout      (Timeout)
    ) dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .in_word    (in_word),
        .out_data   (out_data),
        .out_c      (out_c),
        .out_de     (out_de),
        .out_locked (out_locked),
        .out_offset (out_offset)
    );

    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        else
            passCount++;
    endtask

    function automatic int tokIdx(input logic [9:0] s);
        case (s)
            TokC00:  return 0;
            TokC01:  return 1;
            TokC10:  return 2;
            TokC11:  return 3;
            default: return -1;
        endcase
    endfunction

    // Data byte recovery: undo the optional inversion, then each bit is the
    // transition between neighbours, complemented (bits 1..7) for XNOR coding.
    function automatic logic [7:0] decodeData(input logic [9:0] s);
        logic [7:0] d;
        d = s[9] ? ~s[7:0] : s[7:0];
        return d ^ (d << 1) ^ (s[8] ? 8'h00 : 8'hFE);
    endfunction

    function automatic logic [9:0] randData();
        logic [9:0] v;
        v = 10'($urandom);
        if (tokIdx(v) >= 0) v = v ^ 10'h001;
        return v;
    endfunction

    function automatic logic [9:0] tokenFor(input int c);
        case (c)
            1:       return TokC01;
            2:       return TokC10;
            3:       return TokC11;
            default: return TokC00;
        endcase
    endfunction

    task automatic modelReset();
        mPrev = '0; mSym = '0; mSymPrev = '0;
        mOffset = 0; mRun = 0; mDwell = 0; mTimeout = 0;
        mLocked = 0; mSkip = 0; mDe = 0; mData = '0; mC = '0;
    endtask

    // One pixel clock of the lane: judge the current symbol, then take the
    // next slice out of the two latest words at the offset in force now.
    task automatic modelStep(input logic [9:0] w);
        int         idx, runNext, oldOffset;
        logic [19:0] win;
        idx       = tokIdx(mSym);
        oldOffset = mOffset;
        if (!mLocked) begin
            if (mSkip)                            runNext = 0;
            else if (idx >= 0 && mSym == mSymPrev) runNext = mRun + 1;
            else                                  runNext = (idx >= 0) ? 1 : 0;
            mSkip = 0;
            if (runNext >= LockCount) begin
                mLocked = 1; mRun = 0; mDwell = 0; mTimeout = 0;
            end else if (mDwell == Dwell - 1) begin
                mOffset = (mOffset + 1) % 10; mRun = 0; mDwell = 0; mSkip = 1;
            end else begin
                mRun = runNext; mDwell = mDwell + 1;
            end
        end else begin
            if (idx >= 0) mTimeout = 0;
            else if (mTimeout == Timeout - 1) begin
                mLocked = 0; mOffset = (mOffset + 1) % 10;
                mTimeout = 0; mRun = 0; mDwell = 0; mSkip = 1;
            end else mTimeout = mTimeout + 1;
        end
        if (idx >= 0) begin
            mC = 2'(idx); mDe = 0; mData = '0;
        end else if (mLocked) begin
            mDe = 1; mData = decodeData(mSym);
        end else begin
            mDe = 0; mData = '0;
        end
        win      = {w, mPrev};
        mSymPrev = mSym;
        mSym     = 10'(win >> oldOffset);
        mPrev    = w;
    endtask

    always @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) modelReset();
        else        modelStep(in_word);
    end

    always @(negedge clk_pixel) begin
        if (rst_n) begin
            checkOutput("cyc_data",   32'(out_data),   32'(mData));
            checkOutput("cyc_c",      32'(out_c),      32'(mC));
            checkOutput("cyc_de",     32'(out_de),     32'(mDe));
            checkOutput("cyc_locked", 32'(out_locked), 32'(mLocked));
            checkOutput("cyc_offset", 32'(out_offset), 32'(mOffset));
        end
    end

    // Serialise one symbol; the deserializer sees it delayed by 'rot' bits.
    task automatic applyStimulus(input logic [9:0] sym);
        logic [19:0] pair;
        pair    = {sym, lastSym} >> (10 - rot);
        in_word = pair[9:0];
        lastSym = sym;
        @(negedge clk_pixel);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        rst_n = 1'b1;
    endtask

    task automatic waitLock(input string tag, input logic [9:0] sym, input int maxCycles);
        int n;
        n = 0;
        while (out_locked !== 1'b1 && n < maxCycles) begin
            applyStimulus(sym);
            n++;
        end
        checkOutput(tag, 32'(out_locked), 32'd1);
    endtask

    task automatic waitUnlock(input string tag, input logic [9:0] sym, input int maxCycles);
        int n;
        n = 0;
        while (out_locked !== 1'b0 && n < maxCycles) begin
            applyStimulus(sym);
            n++;
        end
        checkOutput(tag, 32'(out_locked), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"},   32'(out_data),   32'd0);
        checkOutput({tag, "_c"},      32'(out_c),      32'd0);
        checkOutput({tag, "_de"},     32'(out_de),     32'd0);
        checkOutput({tag, "_locked"}, 32'(out_locked), 32'd0);
        checkOutput({tag, "_offset"}, 32'(out_offset), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_word = '0;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Aligned control stream
        rot = 0;
        waitLock("lock_aligned", TokC00, LockCount + 3);
        checkOutput("aligned_offset", 32'(out_offset), 32'd0);
        checkOutput("aligned_c",      32'(out_c),      32'd0);
        checkOutput("aligned_de",     32'(out_de),     32'd0);

        // Data decode while locked
        applyStimulus(10'h1FF);
        applyStimulus(10'h100);
        applyStimulus(10'h2FF);
        checkOutput("data_1ff", 32'(out_data), 32'h01);
        checkOutput("de_1ff",   32'(out_de),   32'd1);
        checkOutput("c_held",   32'(out_c),    32'd0);
        applyStimulus(TokC00);
        checkOutput("data_100", 32'(out_data), 32'h00);
        checkOutput("de_100",   32'(out_de),   32'd1);
        applyStimulus(TokC00);
        checkOutput("data_2ff", 32'(out_data), 32'hFE);
        applyStimulus(TokC00);
        checkOutput("de_token", 32'(out_de), 32'd0);

        // Loss of sync after Timeout data-only symbols
        for (int i = 0; i < Timeout; i++) applyStimulus(randData());
        applyStimulus(TokC00);
        checkOutput("still_locked", 32'(out_locked), 32'd1);
        applyStimulus(TokC00);
        checkOutput("drop_locked", 32'(out_locked), 32'd0);
        checkOutput("drop_de",     32'(out_de),     32'd0);
        checkOutput("drop_offset", 32'(out_offset), 32'd1);
        waitLock("relock_sweep", TokC00, 12 * Dwell);
        checkOutput("relock_offset", 32'(out_offset), 32'd0);

        // A single token just before expiry keeps lock
        for (int i = 0; i < Timeout - 2; i++) applyStimulus(randData());
        applyStimulus(TokC00);
        for (int i = 0; i < 10; i++) applyStimulus(randData());
        applyStimulus(TokC00);
        applyStimulus(TokC00);
        checkOutput("keep_locked", 32'(out_locked), 32'd1);

        // Slipped stream, rotation 6
        doReset();
        rot = 6;
        waitLock("lock_slip", TokC01, 12 * Dwell);
        checkOutput("slip_offset", 32'(out_offset), 32'd6);
        checkOutput("slip_c",      32'(out_c),      32'd1);

        // Asynchronous reset while locked
        @(posedge clk_pixel);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(negedge clk_pixel);
        rst_n = 1'b1;
        rot = 0;
        waitLock("lock_after_reset", TokC00, LockCount + 3);
        checkOutput("after_reset_offset", 32'(out_offset), 32'd0);

        // Wrap-around: lock at 9, slip by one, relock at 0
        doReset();
        rot = 9;
        waitLock("lock_wrap", TokC00, 12 * Dwell);
        checkOutput("wrap_offset9", 32'(out_offset), 32'd9);
        rot = 0;
        waitUnlock("drop_wrap", TokC00, Timeout + 10);
        checkOutput("wrap_offset0", 32'(out_offset), 32'd0);
        waitLock("relock_wrap", TokC00, LockCount + 4);
        checkOutput("relock_wrap_offset", 32'(out_offset), 32'd0);

        // Randomised streams against the model
        for (int round = 0; round < 25; round++) begin
            int c;
            rot = $urandom_range(0, 9);
            c   = $urandom_range(0, 3);
            for (int seg = 0; seg < 6; seg++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int len;
                    len = $urandom_range(1, 90);
                    for (int k = 0; k < len; k++) applyStimulus(randData());
                end else begin
                    int len;
                    len = $urandom_range(1, 200);
                    for (int k = 0; k < len; k++) begin
                        if ($urandom_range(0, 15) == 0)
                            applyStimulus(tokenFor($urandom_range(0, 3)));
                        else
                            applyStimulus(tokenFor(c));
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
